// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and iteration constants.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational sign handling: operand magnitudes on the way in, result
// negation on the way out.
module mdu_signfix
    import mdu_pkg::*;
(
    input  logic                   is_signed,
    input  logic [MDU_WIDTH-1:0]   a,
    input  logic [MDU_WIDTH-1:0]   b,
    output logic [MDU_WIDTH-1:0]   a_mag,
    output logic [MDU_WIDTH-1:0]   b_mag,
    output logic                   a_neg,
    output logic                   b_neg,
    input  logic [2*MDU_WIDTH-1:0] res,
    input  logic                   neg_full,
    input  logic                   neg_hi,
    input  logic                   neg_lo,
    output logic [2*MDU_WIDTH-1:0] fixed
);

    // Operand magnitude extraction
    always_comb begin
        a_neg = is_signed & a[MDU_WIDTH-1];
        b_neg = is_signed & b[MDU_WIDTH-1];
        if (a_neg) a_mag = 32'd0 - a;
        else       a_mag = a;
        if (b_neg) b_mag = 32'd0 - b;
        else       b_mag = b;
    end

    // Result negation: whole 64-bit product, or HI/LO halves independently
    always_comb begin
        fixed = res;
        if (neg_full) begin
            fixed = 64'd0 - res;
        end else begin
            if (neg_hi) fixed[63:32] = 32'd0 - res[63:32];
            else        fixed[63:32] = res[63:32];
            if (neg_lo) fixed[31:0]  = 32'd0 - res[31:0];
            else        fixed[31:0]  = res[31:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers;
// one shift-add or restoring-subtract step per cycle on operand magnitudes.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [MDU_WIDTH-1:0] rs_data,
    input  logic [MDU_WIDTH-1:0] rt_data,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic [MDU_WIDTH-1:0] mt_data,
    output logic                 busy,
    output logic                 done,
    output logic [MDU_WIDTH-1:0] hi,
    output logic [MDU_WIDTH-1:0] lo
);

    localparam logic [4:0] CNT_LAST = 5'(MDU_ITER - 1);

    mdu_state_e         state_r, next_state_s;
    logic [1:0]         op_r;
    logic [4:0]         cnt_r;
    logic [32:0]        work_hi_r;
    logic [31:0]        work_lo_r;
    logic [31:0]        operand_r;
    logic               a_neg_r, b_neg_r, div_zero_r;
    logic               busy_r, done_r;
    logic [31:0]        hi_r, lo_r;

    logic [31:0]        a_mag_s, b_mag_s;
    logic               a_neg_s, b_neg_s;
    logic [32:0]        mul_sum_s, div_shift_s, div_diff_s;
    logic               div_ge_s;
    logic               neg_full_s, neg_hi_s, neg_lo_s;
    logic [63:0]        fixed_s;

    mdu_signfix u_signfix (
        .is_signed (op_is_signed(op)),
        .a         (rs_data),
        .b         (rt_data),
        .a_mag     (a_mag_s),
        .b_mag     (b_mag_s),
        .a_neg     (a_neg_s),
        .b_neg     (b_neg_s),
        .res       ({work_hi_r[31:0], work_lo_r}),
        .neg_full  (neg_full_s),
        .neg_hi    (neg_hi_s),
        .neg_lo    (neg_lo_s),
        .fixed     (fixed_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = RUN;
                else       next_state_s = IDLE;
            end
            RUN: begin
                if (cnt_r == CNT_LAST) next_state_s = FIX;
                else                   next_state_s = RUN;
            end
            FIX:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Iteration step and sign-correction selects
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_r[31:0]} + (work_lo_r[0] ? {1'b0, operand_r} : 33'd0);
        div_shift_s = {work_hi_r[31:0], work_lo_r[31]};
        div_ge_s    = (div_shift_s >= {1'b0, operand_r});
        div_diff_s  = div_shift_s - {1'b0, operand_r};
        neg_full_s  = op_is_signed(op_r) & ~op_is_div(op_r) & (a_neg_r ^ b_neg_r);
        neg_hi_s    = op_is_signed(op_r) &  op_is_div(op_r) & a_neg_r;
        // A zero divisor always yields an all-ones quotient, whatever the signs
        neg_lo_s    = op_is_signed(op_r) &  op_is_div(op_r) & (a_neg_r ^ b_neg_r) & ~div_zero_r;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r       <= 2'b00;
            cnt_r      <= 5'd0;
            work_hi_r  <= 33'd0;
            work_lo_r  <= 32'd0;
            operand_r  <= 32'd0;
            a_neg_r    <= 1'b0;
            b_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mthi) hi_r <= mt_data;
                    if (mtlo) lo_r <= mt_data;
                    if (start) begin
                        op_r       <= op;
                        cnt_r      <= 5'd0;
                        a_neg_r    <= a_neg_s;
                        b_neg_r    <= b_neg_s;
                        div_zero_r <= (rt_data == 32'd0);
                        work_hi_r  <= 33'd0;
                        if (op_is_div(op)) begin
                            operand_r <= b_mag_s;
                            work_lo_r <= a_mag_s;
                        end else begin
                            operand_r <= a_mag_s;
                            work_lo_r <= b_mag_s;
                        end
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_is_div(op_r)) begin
                        if (div_ge_s) begin
                            work_hi_r <= div_diff_s;
                            work_lo_r <= {work_lo_r[30:0], 1'b1};
                        end else begin
                            work_hi_r <= div_shift_s;
                            work_lo_r <= {work_lo_r[30:0], 1'b0};
                        end
                    end else begin
                        work_hi_r <= {1'b0, mul_sum_s[32:1]};
                        work_lo_r <= {mul_sum_s[0], work_lo_r[31:1]};
                    end
                end
                FIX: begin
                    hi_r   <= fixed_s[63:32];
                    lo_r   <= fixed_s[31:0];
                    done_r <= 1'b1;
                    cnt_r  <= 5'd0;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] mt_data = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    mult_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag, input bit interfere);
        int k;
        int d0;
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs_data = ~a;
        rt_data = ~b;
        check({tag, " busy"}, 64'(busy), 64'd1);
        d0 = done_cnt;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (interfere && k == 10) begin
                start = 1'b1; op = 2'b11; mtlo = 1'b1; mt_data = 32'hDEADBEEF;
            end else begin
                start = 1'b0; mtlo = 1'b0;
            end
        end
        start = 1'b0; mtlo = 1'b0;
        check({tag, " latency"}, 64'(k), 64'd33);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        @(posedge clk); #1;
        check({tag, " done_low"}, 64'(done), 64'd0);
        check({tag, " pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7", 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1", 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin", 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2", 1'b0);
        run_op(2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_by0", 1'b0);
        run_op(2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg_by0", 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf", 1'b0);
        run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2", 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7", 1'b0);

        // Move-to-HI/LO in idle
        @(negedge clk);
        mthi = 1'b1; mt_data = 32'h12345678;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'h12345678);
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both hi", 64'(hi), 64'hCAFEF00D);
        check("mt_both lo", 64'(lo), 64'hCAFEF00D);

        // start and mtlo while busy are ignored
        run_op(2'b01, 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000, "multu_interfere", 1'b1);

        // Reset mid-divide aborts with no done pulse
        @(negedge clk);
        mthi = 1'b1; mt_data = 32'h5A5A5A5A;
        @(posedge clk); #1;
        mthi = 1'b0;
        @(negedge clk);
        op = 2'b10; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort no_pulse", 64'(done_cnt - d0), 64'd0);
        run_op(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, "div_after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; the width is fixed at 32 bits and the iteration count is fixed at 32.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request an operation; sampled only while busy=0.
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  in  32  operand A from register-file read port 1; multiplicand or dividend.
REQ-007 rt_data  in  32  operand B from register-file read port 2; multiplier or divisor.
REQ-008 mthi  in  1  write mt_data into HI.
REQ-009 mtlo  in  1  write mt_data into LO.
REQ-010 mt_data  in  32  data for mthi/mtlo.
REQ-011 busy  out  1  an operation is in progress.
REQ-012 done  out  1  one-cycle pulse in the cycle that HI/LO hold a new result.
REQ-013 hi  out  32  HI register; feeds the register-file write_data mux for MFHI.
REQ-014 lo  out  32  LO register; feeds the register-file write_data mux for MFLO.

Function
REQ-015 FSM states:
- IDLE: start=1 latches op, rs_data and rt_data, then moves to RUN with iteration counter=0.
- RUN: one shift-add or restoring-subtract step per cycle; after counter=31 it moves to FIX.
- FIX: sign correction, HI/LO write, done=1, then back to IDLE.
REQ-016 Latency: start sampled at edge N; busy=1 from edge N to edge N+33; HI/LO updated and done=1 after edge N+33; busy=0 in that same cycle.
REQ-017 done stays high for exactly one cycle; it is never high in any other cycle.
REQ-018 MULT/MULTU: {HI,LO} = the 64-bit product. MULT treats the operands as two's-complement; MULTU treats them as unsigned.
REQ-019 DIV/DIVU: LO = quotient, HI = remainder. For signed division the quotient is truncated toward zero, the quotient sign is sign(A) xor sign(B), and the remainder sign equals the sign of A.
REQ-020 Signed operations run on magnitudes; negation is applied in FIX, never during RUN.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0x00000000, with no exception.
REQ-022 Divisor 0 (DIV or DIVU) gives LO=0xFFFFFFFF and HI=A, with normal latency and a normal done pulse.
REQ-023 start while busy=1 is ignored; the operation in flight is unaffected.
REQ-024 mthi/mtlo while busy=1 are ignored.
REQ-025 mthi/mtlo in IDLE write on the next edge; both may assert in the same cycle, and each then writes its own register.
REQ-026 mthi/mtlo together with start in IDLE: the mt write takes effect, then the result overwrites it at edge N+33.
REQ-027 Operand inputs may change after edge N without affecting the result.
REQ-028 hi and lo are register outputs with no combinational path from any input.

Reset
REQ-029 rst=1 forces IDLE, busy=0, done=0, hi=0x00000000, lo=0x00000000, and counter=0, asynchronously.
REQ-030 rst during RUN or FIX aborts the operation: no done pulse, and HI/LO are cleared.
REQ-031 After rst deasserts, the first start is accepted on the first rising edge.

Structure
REQ-032 Shared package mdu_pkg SHALL hold:
- op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
- state enumeration (IDLE, RUN, FIX)
- constant MDU_ITER=32
REQ-033 One combinational sub-module, mdu_signfix, SHALL perform operand magnitude extraction and result negation; sequential logic stays in mult_div_unit.

Verification
REQ-034 MULT A=0xFFFFFFFD (-3), B=0x00000007 -> done 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-037 Sequence:
- mthi with mt_data=0x12345678 in IDLE -> hi=0x12345678.
- Start a MULTU, then assert start and mtlo at cycle 10 -> both ignored; single done pulse; result correct.
REQ-038 DIV started; rst pulsed at cycle 15 -> busy=0 and hi=lo=0 immediately; no done pulse; the next start completes normally.
